// File: rtl/sprite_anim_renderer.sv
// Sprite pixel pipeline: animated multi-frame sprite with placement, horizontal flip,
// transparency key and a run-time writable palette. Two-cycle latency from draw_x/draw_y/blank
// to rgb/pixel_valid; the sprite ROM is clocked on the falling edge between the two stages.
module sprite_anim_renderer #(
  parameter int unsigned SPR_W  = 100,
  parameter int unsigned SPR_H  = 120,
  parameter int unsigned FRAMES = 4,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned TRANSP = 0,
  parameter int unsigned HOLD   = 6,
  localparam int unsigned FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         draw_x,
  input  logic [9:0]         draw_y,
  input  logic               blank,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               flip_h,
  input  logic               frame_tick,
  input  logic               anim_start,
  input  logic               anim_loop,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  input  logic               pal_we,
  input  logic [IDX_W-1:0]   pal_idx,
  input  logic [11:0]        pal_rgb,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               pixel_valid,
  output logic               anim_busy,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam int unsigned HOLD_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned FRAME_SZ = SPR_W * SPR_H;
  localparam int unsigned PAL_N    = 2 ** IDX_W;

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  state_e              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                loop_q;
  logic                vis_q;
  logic [11:0]         pal_mem [PAL_N];

  logic [10:0] dx;
  logic [10:0] dy;
  logic        hit;
  logic [31:0] col;
  logic [31:0] addr_full;

  // S0 geometry: sprite-relative offsets, hit test and linear ROM address.
  always_comb begin
    dx        = {1'b0, draw_x} - {1'b0, pos_x};
    dy        = {1'b0, draw_y} - {1'b0, pos_y};
    // Explicit ordering compare so draw < pos is always a miss, independent of sprite size.
    hit       = (draw_x >= pos_x) && (32'(dx) < SPR_W) &&
                (draw_y >= pos_y) && (32'(dy) < SPR_H);
    col       = flip_h ? (SPR_W - 1 - 32'(dx)) : 32'(dx);
    addr_full = 32'(anim_frame) * FRAME_SZ + 32'(dy) * SPR_W + col;
  end

  // S0 register: ROM address every cycle, visibility delayed to line up with rom_q.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rom_addr <= '0;
      vis_q    <= 1'b0;
    end else begin
      rom_addr <= addr_full[ADDR_W-1:0];
      vis_q    <= blank & hit;
    end
  end

  // S1 register and palette: colour lookup reads the pre-write palette on a same-edge write.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pixel_valid <= 1'b0;
      for (int i = 0; i < PAL_N; i++) pal_mem[i] <= '0;
    end else begin
      if (pal_we) pal_mem[pal_idx] <= pal_rgb;
      if (vis_q && (rom_q != IDX_W'(TRANSP))) begin
        {red, green, blue} <= pal_mem[rom_q];
        pixel_valid        <= 1'b1;
      end else begin
        {red, green, blue} <= '0;
        pixel_valid        <= 1'b0;
      end
    end
  end

  // Animation FSM: frame advances only on frame_tick, so never mid-line.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      loop_q     <= 1'b0;
      anim_frame <= '0;
      anim_busy  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (anim_start) begin
            state_q    <= StPlay;
            hold_q     <= '0;
            loop_q     <= anim_loop;
            anim_frame <= '0;
            anim_busy  <= 1'b1;
          end
        end
        StPlay: begin
          if (anim_start) begin
            // Restart has priority over a coincident tick.
            hold_q     <= '0;
            loop_q     <= anim_loop;
            anim_frame <= '0;
          end else if (frame_tick) begin
            if (hold_q == HOLD_W'(HOLD - 1)) begin
              hold_q <= '0;
              if (anim_frame == FRAME_W'(FRAMES - 1)) begin
                if (loop_q) begin
                  anim_frame <= '0;
                end else begin
                  state_q   <= StDone;
                  anim_busy <= 1'b0;
                end
              end else begin
                anim_frame <= anim_frame + 1'b1;
              end
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          anim_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: table of placement vectors, hand sequences for palette,
// transparency and animation corners, then randomized traffic against an arithmetic model.
module tb_sprite_anim_renderer;

  localparam int W = 100;
  localparam int H = 120;
  localparam int NF = 4;
  localparam int HOLDC = 6;
  localparam int FSZ = W * H;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  draw_x = '0, draw_y = '0, pos_x = '0, pos_y = '0;
  logic        blank = 1'b0, flip_h = 1'b0, frame_tick = 1'b0, anim_start = 1'b0;
  logic        anim_loop = 1'b0, pal_we = 1'b0;
  logic [15:0] rom_addr;
  logic [2:0]  rom_q;
  logic [2:0]  pal_idx = '0;
  logic [11:0] pal_rgb = '0;
  logic [3:0]  red, green, blue;
  logic        pixel_valid, anim_busy;
  logic [1:0]  anim_frame;

  sprite_anim_renderer dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h), .frame_tick(frame_tick),
    .anim_start(anim_start), .anim_loop(anim_loop), .rom_addr(rom_addr), .rom_q(rom_q),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb), .red(red), .green(green),
    .blue(blue), .pixel_valid(pixel_valid), .anim_busy(anim_busy), .anim_frame(anim_frame)
  );

  always #5 vga_clk = ~vga_clk;

  // External ROM clocked on the falling edge.
  logic [2:0] rom_mem [65536];
  always @(negedge vga_clk) rom_q <= rom_mem[rom_addr];

  int nvec = 0;
  int nerr = 0;

  // Reference model state.
  int m_pal [8];
  bit m_vis;
  int m_addr;
  bit m_active, m_loop;
  int m_ticks;

  function automatic int mframe();
    if (!m_active) return 0;
    if (m_loop) return (m_ticks / HOLDC) % NF;
    return (m_ticks / HOLDC >= NF) ? NF - 1 : m_ticks / HOLDC;
  endfunction

  function automatic bit mbusy();
    return m_active && (m_loop || m_ticks < HOLDC * NF);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: predict, advance the model, clock the DUT, compare.
  task automatic cycle();
    int dxv, dyv, col, addr, exp_pix, exp_anim, idx;
    bit hit;
    dxv  = int'(draw_x) - int'(pos_x);
    dyv  = int'(draw_y) - int'(pos_y);
    hit  = dxv >= 0 && dxv < W && dyv >= 0 && dyv < H;
    col  = flip_h ? (W - 1 - dxv) : dxv;
    addr = (mframe() * FSZ + dyv * W + col) & 32'hFFFF;
    exp_pix = 0;
    if (reset_n && m_vis) begin
      idx = int'(rom_mem[m_addr]);
      if (idx != 0) exp_pix = 32'h1000 | m_pal[idx];
    end
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_pal[i] = 0;
      m_vis = 0; m_addr = 0; m_active = 0; m_loop = 0; m_ticks = 0;
    end else begin
      if (pal_we) m_pal[pal_idx] = int'(pal_rgb);
      m_vis  = blank && hit;
      m_addr = addr;
      if (anim_start) begin
        m_active = 1; m_loop = anim_loop; m_ticks = 0;
      end else if (frame_tick && mbusy()) begin
        m_ticks++;
        if (m_loop && m_ticks == HOLDC * NF) m_ticks = 0;
      end
    end
    exp_anim = (int'(mbusy()) << 2) | mframe();
    @(posedge vga_clk);
    #1;
    if (!reset_n) chk("rom_addr_reset", int'(rom_addr), 0);
    else if (hit) chk("rom_addr", int'(rom_addr), addr);
    chk("pixel", int'({pixel_valid, red, green, blue}), exp_pix);
    chk("anim", int'({anim_busy, anim_frame}), exp_anim);
  endtask

  task automatic set_draw(input int x, input int y, input bit bl);
    draw_x = 10'(x); draw_y = 10'(y); blank = bl;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1; cycle();
      frame_tick = 0; cycle();
    end
  endtask

  typedef struct {
    int dx; int dy; int px; int py; bit flip; bit hit; int addr;
  } vec_t;
  vec_t vtab [8];

  initial begin
    for (int i = 0; i < 65536; i++) rom_mem[i] = 3'($urandom);
    rom_mem[0] = 3;  // opaque pixel used by palette checks
    rom_mem[5] = 0;  // transparent pixel inside sprite

    vtab[0] = '{100, 50, 100, 50, 1'b0, 1'b1, 0};
    vtab[1] = '{99, 50, 100, 50, 1'b0, 1'b0, 0};
    vtab[2] = '{100, 50, 100, 50, 1'b1, 1'b1, 99};
    vtab[3] = '{199, 169, 100, 50, 1'b1, 1'b1, 11900};
    vtab[4] = '{200, 50, 100, 50, 1'b1, 1'b0, 0};
    vtab[5] = '{150, 60, 100, 50, 1'b0, 1'b1, 1050};
    vtab[6] = '{1023, 1023, 1000, 1000, 1'b0, 1'b1, 2323};
    vtab[7] = '{100, 170, 100, 50, 1'b0, 1'b0, 0};

    // Reset held three cycles with anim_start asserted.
    reset_n = 0; anim_start = 1;
    for (int i = 0; i < 3; i++) cycle();
    reset_n = 1; anim_start = 0;
    cycle();
    chk("reset_busy", int'(anim_busy), 0);
    chk("reset_valid", int'(pixel_valid), 0);

    // Placement / flip table at frame 0.
    for (int i = 0; i < 8; i++) begin
      set_draw(vtab[i].dx, vtab[i].dy, 1);
      pos_x = 10'(vtab[i].px); pos_y = 10'(vtab[i].py); flip_h = vtab[i].flip;
      cycle();
      if (vtab[i].hit) chk("tab_addr", int'(rom_addr), vtab[i].addr);
    end
    flip_h = 0; blank = 0; cycle(); cycle();

    // Palette write then opaque pixel.
    pos_x = 100; pos_y = 50;
    pal_we = 1; pal_idx = 3; pal_rgb = 12'hF80; cycle();
    pal_we = 0;
    set_draw(100, 50, 1); cycle();
    chk("t2_addr", int'(rom_addr), 0);
    set_draw(99, 50, 1); cycle();
    chk("t2_pixel", int'({pixel_valid, red, green, blue}), 'h1F80);
    cycle();
    chk("t2_miss", int'(pixel_valid), 0);

    // Transparent index inside sprite, and blank=0.
    set_draw(105, 50, 1); cycle(); blank = 0; cycle();
    chk("t4_transp", int'({pixel_valid, red, green, blue}), 0);
    set_draw(100, 50, 0); cycle(); cycle();
    chk("t4_blank", int'({pixel_valid, red, green, blue}), 0);

    // One-shot animation.
    anim_loop = 0; anim_start = 1; cycle(); anim_start = 0;
    for (int t = 1; t <= 24; t++) begin
      tick_n(1);
      chk("t5_frame", int'(anim_frame), (t / 6 > 3) ? 3 : t / 6);
      chk("t5_busy", int'(anim_busy), (t < 24) ? 1 : 0);
    end
    tick_n(3);
    chk("t5_done_frame", int'(anim_frame), 3);
    set_draw(100, 50, 1); cycle();
    chk("t5_addr", int'(rom_addr), 36000);
    blank = 0; cycle();

    // Looping animation, restart racing a tick.
    anim_loop = 1; anim_start = 1; cycle(); anim_start = 0;
    tick_n(24);
    chk("t6_wrap", int'({anim_busy, anim_frame}), 'h4);
    tick_n(7);
    chk("t6_f1", int'(anim_frame), 1);
    anim_start = 1; frame_tick = 1; cycle(); anim_start = 0; frame_tick = 0;
    chk("t6_restart", int'(anim_frame), 0);
    tick_n(5);
    chk("t6_hold0", int'(anim_frame), 0);
    tick_n(1);
    chk("t6_hold_adv", int'(anim_frame), 1);

    // Palette write on the same edge as its read returns the old colour.
    anim_start = 1; cycle(); anim_start = 0;
    set_draw(100, 50, 1); cycle();
    pal_we = 1; pal_idx = 3; pal_rgb = 12'h0F0; cycle(); pal_we = 0;
    chk("t6_pal_old", int'({red, green, blue}), 'hF80);
    cycle();
    chk("t6_pal_new", int'({red, green, blue}), 'h0F0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int px, py;
      px = int'($urandom_range(0, 900));
      py = int'($urandom_range(0, 880));
      pos_x = 10'(px); pos_y = 10'(py);
      draw_x = 10'(px + int'($urandom_range(0, 110)) - 5);
      draw_y = 10'(py + int'($urandom_range(0, 130)) - 5);
      blank = ($urandom_range(0, 9) < 8);
      flip_h = 1'($urandom);
      frame_tick = ($urandom_range(0, 9) == 0);
      anim_start = ($urandom_range(0, 49) == 0);
      anim_loop = 1'($urandom);
      pal_we = ($urandom_range(0, 4) == 0);
      pal_idx = 3'($urandom);
      pal_rgb = 12'($urandom);
      reset_n = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
